// File: rtl/mem_pkg.sv
// mem_pkg: shared state encodings and memOp constants for the memory controller and Store/Load FSMs
package mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;
  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ  = 1'b1;
endpackage

// File: rtl/mem_if.sv
// mem_if: requester/memory handshake bus (memEn/memOp/MAR/MDR in, rdata/MFC/status out)
interface mem_if #(parameter int ADDR_W = 6, parameter int DATA_W = 16);
  logic              mem_en;
  logic              mem_op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mfc;
  logic              busy;
  logic              proto_err;
  modport master (output mem_en, mem_op, addr, wdata, input rdata, mfc, busy, proto_err);
  modport slave  (input mem_en, mem_op, addr, wdata, output rdata, mfc, busy, proto_err);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with registered read port
module mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory responder with programmable wait states and 4-phase MFC handshake
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input logic   clk,
  input logic   reset,
  mem_if.slave  bus
);
  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dout, rdata_q;
  logic              op_q, rd_q, mfc_q, perr_q, we;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.mem_en ? (WAIT_STATES == 0 ? ACCESS : WAIT) : IDLE;
      WAIT:    state_nx = !bus.mem_en ? IDLE : (cnt == 4'(WAIT_STATES - 1) ? ACCESS : WAIT);
      ACCESS:  state_nx = DONE;
      default: state_nx = bus.mem_en ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= MEM_WRITE;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      mfc_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= state == WAIT ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && bus.mem_en) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        op_q    <= bus.mem_op;
      end
      // RAM output is registered, so read data lands one edge after ACCESS, together with MFC
      rd_q    <= state == ACCESS && op_q == MEM_READ;
      if (rd_q) rdata_q <= dout;
      mfc_q   <= state == DONE;
      perr_q  <= state == WAIT && !bus.mem_en;
    end
  end
  assign we            = state == ACCESS && op_q == MEM_WRITE;
  assign bus.rdata     = rdata_q;
  assign bus.mfc       = mfc_q;
  assign bus.busy      = state != IDLE;
  assign bus.proto_err = perr_q;
  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (addr_q),
    .din  (wdata_q),
    .dout (dout)
  );
endmodule
